// File: rtl/d_operand_stage.sv
// Decode-to-execute operand stage: RF read addressing, X/W bypass, load-use bubble, D/X register.
// Optional load-use bubble counter (stall_cnt) is built when DOS_STALL_CNT_EN is defined.
module d_operand_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [XLEN-1:0] dec_pc,
  input  logic [31:0]     dec_inst,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            x_rd_valid,
  input  logic [4:0]      x_rd,
  input  logic            x_rd_ready,
  input  logic [XLEN-1:0] x_data,
  input  logic            w_we,
  input  logic [4:0]      w_rd,
  input  logic [XLEN-1:0] w_data,
  input  logic            flush,
  input  logic            x_ready,
  output logic            x_valid,
  output logic [XLEN-1:0] x_pc,
  output logic [31:0]     x_inst,
  output logic [XLEN-1:0] x_rs1_val,
  output logic [XLEN-1:0] x_rs2_val
`ifdef DOS_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_OP     = 7'b0110011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  logic [6:0]      opcode;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            haz_rs1;
  logic            haz_rs2;
  logic            hazard;
  logic            load_en;
  logic            accept;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  logic            x_valid_q;
  logic [XLEN-1:0] x_pc_q;
  logic [31:0]     x_inst_q;
  logic [XLEN-1:0] x_rs1_q;
  logic [XLEN-1:0] x_rs2_q;

  // x0 reads as zero even if a stage claims to write it; X beats W beats the array.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      addr,
    input logic [XLEN-1:0] rf_val,
    input logic            xv,
    input logic [4:0]      xrd,
    input logic [XLEN-1:0] xd,
    input logic            wv,
    input logic [4:0]      wrd,
    input logic [XLEN-1:0] wd
  );
    logic [XLEN-1:0] r;
    if (addr == 5'd0)                r = '0;
    else if (xv && (xrd == addr))    r = xd;
    else if (wv && (wrd == addr))    r = wd;
    else                             r = rf_val;
    return r;
  endfunction

  assign opcode      = dec_inst[6:0];
  assign rf_rs1_addr = dec_inst[19:15];
  assign rf_rs2_addr = dec_inst[24:20];

  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL:   uses_rs1 = 1'b0;
      OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs2 = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rs1_val = resolve(rf_rs1_addr, rf_rs1_data, x_rd_valid, x_rd, x_data, w_we, w_rd, w_data);
    rs2_val = resolve(rf_rs2_addr, rf_rs2_data, x_rd_valid, x_rd, x_data, w_we, w_rd, w_data);
  end

  // Only an unready producer in X stalls; W is always forwardable.
  assign haz_rs1 = uses_rs1 && (rf_rs1_addr != 5'd0) && x_rd_valid && (x_rd == rf_rs1_addr) && !x_rd_ready;
  assign haz_rs2 = uses_rs2 && (rf_rs2_addr != 5'd0) && x_rd_valid && (x_rd == rf_rs2_addr) && !x_rd_ready;
  assign hazard  = dec_valid && (haz_rs1 || haz_rs2);

  assign load_en   = !x_valid_q || x_ready;
  assign accept    = load_en && dec_valid && !hazard;
  assign dec_ready = flush || (load_en && !hazard);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_valid_q <= 1'b0;
      x_pc_q    <= '0;
      x_inst_q  <= '0;
      x_rs1_q   <= '0;
      x_rs2_q   <= '0;
    end else if (flush) begin
      x_valid_q <= 1'b0;
    end else if (accept) begin
      x_valid_q <= 1'b1;
      x_pc_q    <= dec_pc;
      x_inst_q  <= dec_inst;
      x_rs1_q   <= rs1_val;
      x_rs2_q   <= rs2_val;
    end else if (load_en) begin
      x_valid_q <= 1'b0;
    end
  end

  assign x_valid   = x_valid_q;
  assign x_pc      = x_pc_q;
  assign x_inst    = x_inst_q;
  assign x_rs1_val = x_rs1_q;
  assign x_rs2_val = x_rs2_q;

`ifdef DOS_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_en && hazard && !flush) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/d_operand_stage.md
# d_operand_stage

Decode-to-execute operand stage. Takes a decoded instruction from decode and drives the register file read addresses from it. It resolves rs1/rs2 values with bypass from the execute (X) and writeback (W) stages, inserts a bubble on a load-use hazard, and holds the result in the D/X pipeline register under a valid/ready handshake. It sits between decode and execute and is the sole consumer of the register file read ports.

## Interface
- XLEN, 32, datapath width (fixed at 32 for RV32I)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- dec_valid  in  1  instruction on dec_pc/dec_inst is valid
- dec_ready  out  1  stage accepts dec_* this cycle
- dec_pc  in  32  instruction PC
- dec_inst  in  32  raw instruction word
- rf_rs1_addr  out  5  dec_inst[19:15], combinational
- rf_rs2_addr  out  5  dec_inst[24:20], combinational
- rf_rs1_data  in  32  register file read data, asynchronous
- rf_rs2_data  in  32  register file read data, asynchronous
- x_rd_valid  in  1  instruction in X writes x_rd
- x_rd  in  5  X destination register
- x_rd_ready  in  1  x_data is final (0 for a load in X)
- x_data  in  32  X result
- w_we  in  1  W writes w_rd this cycle; same signals as the register file write port
- w_rd  in  5  W destination register
- w_data  in  32  W write data
- flush  in  1  kill the held and incoming instruction
- x_ready  in  1  execute accepts x_* this cycle
- x_valid  out  1  D/X register holds a valid instruction
- x_pc  out  32  registered PC
- x_inst  out  32  registered instruction
- x_rs1_val  out  32  registered resolved rs1 value
- x_rs2_val  out  32  registered resolved rs2 value
- stall_cnt  out  32  load-use bubble count; present only with DOS_STALL_CNT_EN

## Operation
- Use decode from opcode dec_inst[6:0]:
  - uses_rs1 = 0 for LUI 0110111, AUIPC 0010111 and JAL 1101111; 1 otherwise.
  - uses_rs2 = 1 only for OP 0110011, STORE 0100011 and BRANCH 1100011.
- Operand resolve, per operand, in priority order:
  - If the address is 0, the value is 0.
  - Else if x_rd_valid and x_rd matches, the value is x_data.
  - Else if w_we and w_rd matches, the value is w_data.
  - Else the value is rf_*_data.
- The W bypass is mandatory: a register file write is not visible on its read port until the next cycle.
- Hazard: hazard = dec_valid and (per used operand) address ≠ 0, x_rd_valid, x_rd matches and !x_rd_ready.
- Load enable: load_en = !x_valid or x_ready.
- dec_ready = flush or (load_en and !hazard).
- Register update, in priority order:
  - flush: x_valid <= 0; the incoming instruction is dropped.
  - Else if load_en and dec_valid and !hazard: capture dec_pc, dec_inst and the resolved operands; x_valid <= 1.
  - Else if load_en: x_valid <= 0. This is the bubble case, covering both a hazard and no input.
  - Else hold all registers.
- Operands are captured once, at load. A held instruction keeps its values regardless of later W writes.
- When x_valid=0, data outputs keep their last values and carry no meaning.

## Timing
- Reset values: x_valid=0, x_pc=0, x_inst=0, x_rs1_val=0, x_rs2_val=0, stall_cnt=0.
- Latency: an accepted instruction appears on x_* one cycle after the dec_valid and dec_ready handshake.
- Throughput: one instruction per cycle when x_ready=1 and there is no hazard.
- dec_ready, rf_rs*_addr and hazard are combinational. x_* outputs are registered only.
- Load-use: exactly one bubble per cycle that X holds an unready matching load. The instruction is accepted in the first cycle that x_rd_ready=1 or X no longer matches.
- A flush coincident with hazard, x_ready=0 or dec_valid follows the flush rule: x_valid=0 on the next edge.
- Reset asserted mid-stall clears x_valid asynchronously. After release, the first posedge may accept.

## Configuration
- DOS_STALL_CNT_EN defined:
  - stall_cnt port exists.
  - It increments by 1 on each posedge where load_en and dec_valid and hazard and !flush.
  - It wraps 0xFFFFFFFF to 0.
  - It is cleared only by reset.
- DOS_STALL_CNT_EN undefined: no counter and no stall_cnt port. All other behaviour is identical.

## Test plan
- Reset: hold reset=0 for 2 cycles with dec_valid=1 -> x_valid=0, all x_* 0, dec_ready=1 after release with x_ready=1.
- Plain flow: ADDI x5,x1,3 (0x00308293), rf_rs1_data=0x10, no bypass -> x_valid=1 next cycle, x_rs1_val=0x10, x_pc=dec_pc.
- Bypass priority:
  - rs1=x2 with x_rd=2 (x_data=0xAA, ready), w_rd=2 (w_data=0xBB) and rf=0xCC -> x_rs1_val=0xAA.
  - Same with x_rd_valid=0 -> 0xBB.
  - With rs1=x0 and all bypasses targeting x0 -> 0.
- Load-use: X holds a load to x7 with x_rd_ready=0 for 2 cycles; dec is ADD x8,x7,x1 -> dec_ready=0 and 2 bubbles (x_valid=0), stall_cnt=2. The 3rd cycle accepts with x_data forwarded.
- Backpressure and flush: x_ready=0 with x_valid=1 -> x_* stable and dec_ready=0. Assert flush the same cycle -> dec_ready=1 and x_valid=0 next edge.
- LUI with rs1 field=x7 (matching unready load) -> no stall, accepted next cycle.
